// File: rtl/pipeline_controller_if.sv
// Control/status bundle between the image-pipeline sequencer and its host/datapath.
// master drives commands and the done strobe; slave is the controller.
interface pipeline_controller_if #(
  parameter int PASS_W  = 3,
  parameter int FRAME_W = 8
);
  // done is a one-cycle completion strobe with no back-pressure: every cycle it is
  // high while the controller is in a phase that waits for it counts as one step.
  logic               start;
  logic               continuous;
  logic               abort;
  logic               done;
  logic               on_off;
  logic               rw;
  logic               camera_trigger;
  logic               filter_en;
  logic [PASS_W-1:0]  pass_idx;
  logic               busy;
  logic               frame_done;
  logic [FRAME_W-1:0] frame_cnt;
  logic               timeout_err;
  logic [2:0]         state_dbg;

  modport master (
    output start, continuous, abort, done,
    input  on_off, rw, camera_trigger, filter_en, pass_idx, busy,
    input  frame_done, frame_cnt, timeout_err, state_dbg
  );

  modport slave (
    input  start, continuous, abort, done,
    output on_off, rw, camera_trigger, filter_en, pass_idx, busy,
    output frame_done, frame_cnt, timeout_err, state_dbg
  );
endinterface

// File: rtl/pipeline_controller.sv
// Frame sequencer: capture -> gray write -> NUM_PASSES filter passes -> finish.
// Optional per-phase watchdog enabled by defining PIPELINE_CONTROLLER_TIMEOUT_EN.
module pipeline_controller #(
  parameter int NUM_PASSES     = 2,
  parameter int PASS_W         = 3,
  parameter int FRAME_W        = 8,
  parameter int TIMEOUT_CYCLES = 1000000
) (
  input  logic                  clk,
  input  logic                  erst_n,
  pipeline_controller_if.slave  bus
);

  typedef enum logic [2:0] {
    S_IDLE        = 3'd0,
    S_CAMERA_READ = 3'd1,
    S_GRAY_WRITE  = 3'd2,
    S_FILTER      = 3'd3,
    S_FINISH      = 3'd4
  } state_t;

  state_t             state, nxt_state;
  logic [PASS_W-1:0]  pass_q, nxt_pass;
  logic               tmo_hit;
  logic               on_off_q, rw_q, trig_q, filt_q, busy_q, fdone_q;
  logic [FRAME_W-1:0] frame_cnt_q;
  logic               tmo_err_q;

  always_comb begin
    nxt_state = state;
    nxt_pass  = pass_q;
    case (state)
      S_IDLE:        if (bus.start) nxt_state = S_CAMERA_READ;
      S_CAMERA_READ: if (bus.done)  nxt_state = S_GRAY_WRITE;
      S_GRAY_WRITE:  if (bus.done)  nxt_state = S_FILTER;
      S_FILTER: begin
        if (bus.done) begin
          if (pass_q == PASS_W'(NUM_PASSES - 1)) nxt_state = S_FINISH;
          else                                   nxt_pass  = pass_q + PASS_W'(1);
        end
      end
      S_FINISH:      nxt_state = bus.continuous ? S_CAMERA_READ : S_IDLE;
      default:       nxt_state = S_IDLE;
    endcase
    if (tmo_hit) nxt_state = S_IDLE;
    // Abort outranks both done and the watchdog.
    if (state != S_IDLE && bus.abort) nxt_state = S_IDLE;
    if (nxt_state != S_FILTER) nxt_pass = '0;
  end

  always_ff @(posedge clk) begin
    if (!erst_n) begin
      state       <= S_IDLE;
      pass_q      <= '0;
      on_off_q    <= 1'b0;
      rw_q        <= 1'b0;
      trig_q      <= 1'b0;
      filt_q      <= 1'b0;
      busy_q      <= 1'b0;
      fdone_q     <= 1'b0;
      frame_cnt_q <= '0;
    end else begin
      state    <= nxt_state;
      pass_q   <= nxt_pass;
      on_off_q <= (nxt_state == S_CAMERA_READ) || (nxt_state == S_GRAY_WRITE) ||
                  (nxt_state == S_FILTER);
      rw_q     <= (nxt_state == S_CAMERA_READ);
      trig_q   <= (nxt_state == S_CAMERA_READ);
      filt_q   <= (nxt_state == S_FILTER);
      busy_q   <= (nxt_state != S_IDLE);
      fdone_q  <= (nxt_state == S_FINISH);
      // Count on entry to FINISH so the count moves together with frame_done.
      if (nxt_state == S_FINISH && state != S_FINISH) frame_cnt_q <= frame_cnt_q + FRAME_W'(1);
    end
  end

`ifdef PIPELINE_CONTROLLER_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);

  logic [CNT_W-1:0] phase_cnt;
  logic             in_phase;

  assign in_phase = (state == S_CAMERA_READ) || (state == S_GRAY_WRITE) || (state == S_FILTER);
  assign tmo_hit  = in_phase && !bus.done && (phase_cnt == CNT_W'(TIMEOUT_CYCLES - 1));

  // Each filter pass is its own phase, so an accepted done restarts the count.
  always_ff @(posedge clk) begin
    if (!erst_n) begin
      phase_cnt <= '0;
      tmo_err_q <= 1'b0;
    end else begin
      if (nxt_state != state || (state == S_FILTER && bus.done)) phase_cnt <= '0;
      else if (in_phase)                                         phase_cnt <= phase_cnt + CNT_W'(1);
      if (tmo_hit && !bus.abort)           tmo_err_q <= 1'b1;
      else if (state == S_IDLE && bus.start) tmo_err_q <= 1'b0;
    end
  end
`else
  logic unused_tmo_cfg;

  assign tmo_hit        = 1'b0;
  assign tmo_err_q      = 1'b0;
  assign unused_tmo_cfg = (TIMEOUT_CYCLES > 0);
`endif

  assign bus.on_off         = on_off_q;
  assign bus.rw             = rw_q;
  assign bus.camera_trigger = trig_q;
  assign bus.filter_en      = filt_q;
  assign bus.pass_idx       = pass_q;
  assign bus.busy           = busy_q;
  assign bus.frame_done     = fdone_q;
  assign bus.frame_cnt      = frame_cnt_q;
  assign bus.timeout_err    = tmo_err_q;
  assign bus.state_dbg      = state;

endmodule

// File: doc/pipeline_controller.md
PIPELINE_CONTROLLER -- requirements
Module: pipeline_controller

Interface
REQ-001 Parameter NUM_PASSES, default 2; number of filter passes after the gray write, legal 1..8.
REQ-002 Parameter PASS_W, default 3; width of pass_idx, SHALL satisfy 2**PASS_W >= NUM_PASSES.
REQ-003 Parameter FRAME_W, default 8; width of frame_cnt.
REQ-004 Parameter TIMEOUT_CYCLES, default 1000000; watchdog limit per phase.
REQ-005 clk  input  1  single clock; all logic on rising edge.
REQ-006 erst_n  input  1  synchronous active-low reset, sampled on rising edge of clk.
REQ-007 start  input  1  level start command, sampled only in IDLE.
REQ-008 continuous  input  1  1 = restart capture automatically after each frame, sampled at end of frame.
REQ-009 abort  input  1  synchronous abort request, honoured in any non-IDLE state.
REQ-010 done  input  1  single-cycle phase-complete strobe from the memory/filter datapath.
REQ-011 on_off  output  1  datapath enable.
REQ-012 rw  output  1  1 = datapath reads (capture), 0 = datapath writes.
REQ-013 camera_trigger  output  1  camera capture enable.
REQ-014 filter_en  output  1  filter pass active.
REQ-015 pass_idx  output  PASS_W  index of current filter pass.
REQ-016 busy  output  1  high in every state except IDLE.
REQ-017 frame_done  output  1  one-cycle pulse when a frame completes all passes.
REQ-018 frame_cnt  output  FRAME_W  count of completed frames, wraps modulo 2**FRAME_W.
REQ-019 timeout_err  output  1  sticky watchdog error flag.

Function
REQ-020 The block SHALL be a registered Moore FSM with states IDLE, CAMERA_READ, GRAY_WRITE, FILTER, FINISH; all outputs SHALL be registered decodes of the state and SHALL never be high-impedance.
REQ-021 IDLE: on_off=0, rw=0, camera_trigger=0, filter_en=0, busy=0; start=1 SHALL move to CAMERA_READ next cycle.
REQ-022 CAMERA_READ: on_off=1, rw=1, camera_trigger=1; done=1 SHALL move to GRAY_WRITE.
REQ-023 GRAY_WRITE: on_off=1, rw=0, camera_trigger=0; done=1 SHALL move to FILTER with pass_idx=0.
REQ-024 FILTER: on_off=1, rw=0, filter_en=1; done=1 with pass_idx<NUM_PASSES-1 SHALL increment pass_idx and stay in FILTER; done=1 with pass_idx=NUM_PASSES-1 SHALL move to FINISH.
REQ-025 FINISH SHALL last exactly one cycle, assert frame_done, increment frame_cnt, then go to CAMERA_READ if continuous=1, else IDLE.
REQ-026 done SHALL be ignored in IDLE and FINISH.
REQ-027 Each done strobe SHALL advance exactly one step; done held high N cycles SHALL advance N steps.
REQ-028 abort=1 in any non-IDLE state SHALL force IDLE next cycle without frame_done or frame_cnt change; abort has priority over done.
REQ-029 pass_idx SHALL be 0 outside FILTER.
REQ-030 frame_cnt at 2**FRAME_W-1 SHALL wrap to 0 on the next completed frame.

Reset
REQ-031 erst_n=0 at a rising edge SHALL force IDLE, pass_idx=0, frame_cnt=0, timeout_err=0, frame_done=0, all enables 0, regardless of state or other inputs.
REQ-032 Reset mid-frame SHALL discard the frame; the first cycle after release SHALL present IDLE outputs.

Configuration
REQ-033 Macro PIPELINE_CONTROLLER_TIMEOUT_EN defined: a phase counter SHALL clear on every state change and count cycles in CAMERA_READ, GRAY_WRITE, FILTER; reaching TIMEOUT_CYCLES without done SHALL force IDLE and set timeout_err, cleared only by reset or the next accepted start.
REQ-034 Macro undefined: no counter SHALL be built, timeout_err SHALL be tied 0, phases wait indefinitely for done.

Verification
REQ-035 NUM_PASSES=2, continuous=0: start pulse, done after 5/5/5/5 cycles -> states CAMERA_READ, GRAY_WRITE, FILTER(0), FILTER(1), FINISH; frame_done one cycle; frame_cnt 0->1; IDLE.
REQ-036 continuous=1, three frames of done strobes -> frame_cnt=3, busy never drops, camera_trigger reasserts the cycle after each FINISH.
REQ-037 abort during FILTER pass_idx=1 with simultaneous done -> IDLE next cycle, frame_cnt unchanged, no frame_done.
REQ-038 erst_n low for one cycle during GRAY_WRITE -> all outputs at reset values next cycle; start ignored while erst_n=0.
REQ-039 FRAME_W=2, continuous=1, five frames -> frame_cnt sequence 1,2,3,0,1.
REQ-040 TIMEOUT_EN defined, TIMEOUT_CYCLES=16, no done in CAMERA_READ -> IDLE after 16 cycles, timeout_err=1 until next start.
